if_prefetch: RTL and testbench

//  Parametrised instruction-fetch front end for the next-generation core.

---
 rtl/if_prefetch.sv | 101 ++++++++++
 tb/tb_if_prefetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Decoupled instruction-fetch front end.
// Up to DEPTH fetches are kept in flight to a pipelined, in-order instruction
// memory. Responses are buffered in a FIFO that feeds decode through a
// valid/ready handshake. A redirect flushes the FIFO, marks every in-flight
// response as wrong-path and restarts fetch at the new PC.
module if_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_q, rsp_pc;
  logic [CW-1:0]   inflight, drop, count;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [CW:0]     used;
  logic            accept, push, pop;
  logic [XLEN-1:0] target;

  // Credits: every accepted request owns a FIFO slot until it is popped or
  // dropped, so the FIFO can never overflow.
  assign used   = {1'b0, inflight} + {1'b0, count};
  assign target = redirect_pc & ~XLEN'(3);

  assign imem_req_valid = !rst && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // Wrong-path responses are swallowed while drop is non-zero; a response
  // arriving in the redirect cycle itself is also discarded.
  assign push = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign pop  = instr_valid && instr_ready;

  // Head is gated by the occupancy so outputs read zero when empty.
  assign instr_valid = (count != '0);
  assign instr_out   = instr_valid ? data_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

  // Fetch PC, response PC and in-flight bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      pc_q     <= target;
      rsp_pc   <= target;
      inflight <= inflight - CW'(imem_rsp_valid);
      drop     <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (accept) pc_q <= pc_q + XLEN'(4);
      if (push)   rsp_pc <= rsp_pc + XLEN'(4);
      inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents need no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a pipelined in-order memory model with
// programmable latency, a decode-side collector, a cycle table for the
// streaming start-up and hand-written redirect/reset sequences.
module tb_if_prefetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out, instr_pc;

  if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct {
    logic        rdy;
    logic        req_v;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  req_t        mq[$];
  logic [31:0] got_pc[$];
  int          lat   = 1;
  int          cyc   = 0;
  int          n_acc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: sample handshakes mid-cycle, respond lat cycles after accept.
  always @(negedge clk) begin
    if (rst) mq.delete();
    else begin
      if (imem_rsp_valid) begin
        check("rsp_with_inflight", {31'b0, dut.inflight != '0}, 32'd1);
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_req_addr, cyc + lat});
        n_acc++;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Decode side: log delivered PCs; a handshake in a redirect cycle is discarded.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect_valid) begin
      got_pc.push_back(instr_pc);
      check("instr_data", instr_out, inst_of(instr_pc));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; lat = l; instr_ready = 1'b1; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    step(2);
    rst = 1'b0;
    got_pc.delete();
    n_acc = 0;
  endtask

  task automatic wait_log(input int n, input string name);
    for (int k = 0; k < 60 && got_pc.size() < n; k++) step();
    check(name, {31'b0, got_pc.size() >= n}, 32'd1);
  endtask

  task automatic check_log(input string name, input logic [31:0] base, input int n);
    wait_log(n, name);
    if (got_pc.size() >= n)
      for (int i = 0; i < n; i++) check(name, got_pc[i], base + 32'(4 * i));
  endtask

  vec_t tv[8];

  initial begin
    // Cycle-by-cycle start-up, 1-cycle memory, decode always ready.
    tv[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tv[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tv[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tv[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tv[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tv[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tv[6] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tv[7] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      instr_ready = tv[i].rdy;
      @(negedge clk);
      check("t1_req_valid", {31'b0, imem_req_valid}, {31'b0, tv[i].req_v});
      check("t1_req_addr", imem_req_addr, tv[i].addr);
      check("t1_instr_valid", {31'b0, instr_valid}, {31'b0, tv[i].iv});
      check("t1_instr_pc", instr_pc, tv[i].pc);
      check("t1_instr_out", instr_out, tv[i].iv ? inst_of(tv[i].pc) : 32'h0);
      step();
    end

    // Backpressure: exactly DEPTH requests, FIFO fills, then drains in order.
    do_reset(3);
    instr_ready = 1'b0;
    step(12);
    @(negedge clk);
    check("t2_accepts", 32'(n_acc), 32'd4);
    check("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t2_instr_valid", {31'b0, instr_valid}, 32'd1);
    check("t2_head_pc", instr_pc, 32'h0);
    step();
    instr_ready = 1'b1;
    check_log("t2_order", 32'h0, 6);

    // Redirect with three fetches in flight and none returning that cycle.
    do_reset(4);
    step(3);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check("t3_no_req_at_t", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_fifo_empty", {31'b0, instr_valid}, 32'd0);
    check("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t3_req_addr", imem_req_addr, 32'h100);
    check("t3_drop", {30'b0, dut.drop}, 32'd3);
    check_log("t3_stream", 32'h100, 3);

    // Redirect to an unaligned PC while a response arrives the same cycle.
    do_reset(2);
    step(6);
    check_log("t4_pre", 32'h0, 3);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    check("t4_rsp_at_t", {31'b0, imem_rsp_valid}, 32'd1);
    check("t4_no_req_at_t", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    got_pc.delete();
    @(negedge clk);
    check("t4_req_addr", imem_req_addr, 32'h200);
    check("t4_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("t4_drop", {30'b0, dut.drop}, 32'd1);
    check_log("t4_stream", 32'h200, 3);

    // Back-to-back redirects: the second one wins.
    do_reset(1);
    step(4);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h80;
    @(negedge clk);
    check("t5_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    got_pc.delete();
    @(negedge clk);
    check("t5_req_addr", imem_req_addr, 32'h80);
    check_log("t5_stream", 32'h80, 3);

    // Asynchronous reset mid-stream.
    do_reset(1);
    step(5);
    rst = 1'b1;
    #1;
    check("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t6_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("t6_instr_out", instr_out, 32'h0);
    check("t6_instr_pc", instr_pc, 32'h0);
    step();
    rst = 1'b0;
    got_pc.delete();
    @(negedge clk);
    check("t6_req_valid_rel", {31'b0, imem_req_valid}, 32'd1);
    check("t6_req_addr", imem_req_addr, 32'h0);
    check_log("t6_stream", 32'h0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
